core7_cpu_5_oci_dct_packer: RTL and testbench

Direct-control-transfer (DCT) trace packer for the cpu_5 on-chip instrumentation (OCI) block. It accumulates 2-bit branch-outcome codes from the trace front end and packs them into 30-bit frames, each with an entry count. It delivers the frames over a valid/ready handshake to the trace FIFO and the simulation checker. It is the producer of `dct_buffer`/`dct_count` and generates the `test_ending`/`test_has_ended` end-of-trace signals.

---
 rtl/core7_cpu_5_oci_dct_pkg.sv | 27 ++
 rtl/core7_cpu_5_oci_dct_outreg.sv | 35 +++
 rtl/core7_cpu_5_oci_dct_packer.sv | 124 ++++++++++++
 tb/tb_core7_cpu_5_oci_dct_packer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/core7_cpu_5_oci_dct_pkg.sv
// Shared definitions for the cpu_5 OCI DCT trace packer: code encodings, frame geometry and end-of-trace states.
package core7_cpu_5_oci_dct_pkg;

  localparam int unsigned CODE_W = 2;
  localparam int unsigned DEPTH  = 15;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BUF_W  = CODE_W * DEPTH;

  typedef enum logic [CODE_W-1:0] {
    ILLEGAL   = 2'b00,
    TAKEN     = 2'b01,
    NOT_TAKEN = 2'b10,
    EXC       = 2'b11
  } dct_code_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STOPPING = 2'd1,
    ENDED    = 2'd2
  } end_state_e;

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [BUF_W-1:0] buffer;
  } dct_frame_t;

endpackage

// File: rtl/core7_cpu_5_oci_dct_outreg.sv
// Single-entry valid/ready holding register for packed DCT frames.
module core7_cpu_5_oci_dct_outreg
  import core7_cpu_5_oci_dct_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_i,
  input  dct_frame_t frame_i,
  input  logic       ready_i,
  output logic       valid_o,
  output dct_frame_t frame_o,
  output logic       free_c
);

  logic       valid_q;
  dct_frame_t frame_q;

  // Data is only written on load, so it stays stable while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      frame_q <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      frame_q <= frame_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign free_c  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign frame_o = frame_q;

endmodule

// File: rtl/core7_cpu_5_oci_dct_packer.sv
// Packs 2-bit branch-outcome codes into 15-entry frames and drives the end-of-trace handshake.
module core7_cpu_5_oci_dct_packer
  import core7_cpu_5_oci_dct_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trc_on,
  input  logic              dct_valid,
  input  logic [CODE_W-1:0] dct_code,
  input  logic              dct_flush,
  input  logic              trc_stop,
  input  logic              frame_ready,
  output logic              frame_valid,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic              test_ending,
  output logic              test_has_ended
);

  logic [BUF_W-1:0] acc_q, acc_d, acc_new;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_new;
  logic             wait_q, wait_d;
  logic             ovf_q, ovf_d;
  logic             ending_q, ending_d;
  logic             ended_q, ended_d;
  end_state_e       state_q, state_d;

  logic       code_ok, accept, flush, close, drained;
  logic       out_load, out_free_c;
  dct_frame_t load_frame, out_frame;

  core7_cpu_5_oci_dct_outreg u_outreg (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (out_load),
    .frame_i (load_frame),
    .ready_i (frame_ready),
    .valid_o (frame_valid),
    .frame_o (out_frame),
    .free_c  (out_free_c)
  );

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    state_d    = state_q;
    out_load   = 1'b0;
    code_ok    = trc_on && dct_valid && (dct_code != ILLEGAL);
    accept     = code_ok && !wait_q && (state_q == RUN);
    flush      = (trc_on && dct_flush) || (trc_stop && (state_q == RUN));
    acc_new    = acc_q;
    if (accept) acc_new = acc_q | (BUF_W'(dct_code) << (CODE_W * 32'(cnt_q)));
    cnt_new    = cnt_q + CNT_W'(accept);
    close      = !wait_q && ((cnt_new == CNT_W'(DEPTH)) || (flush && (cnt_new != '0)));
    load_frame = '{count: cnt_new, buffer: acc_new};

    // A held frame drains first; a closing frame parks in WAIT if the output is busy.
    if (wait_q) begin
      if (out_free_c) begin
        out_load   = 1'b1;
        load_frame = '{count: cnt_q, buffer: acc_q};
        acc_d      = '0;
        cnt_d      = '0;
        wait_d     = 1'b0;
      end
    end else if (close) begin
      if (out_free_c) begin
        out_load = 1'b1;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        wait_d = 1'b1;
        acc_d  = acc_new;
        cnt_d  = cnt_new;
      end
    end else begin
      acc_d = acc_new;
      cnt_d = cnt_new;
    end

    ovf_d = (code_ok && wait_q && (state_q == RUN)) || (ovf_q && !ovf_clr);

    // Everything is empty after this edge: no held, partial or output frame.
    drained = !wait_d && (cnt_d == '0) && !out_load && out_free_c;
    case (state_q)
      RUN:      if (trc_stop) state_d = drained ? ENDED : STOPPING;
      STOPPING: if (drained)  state_d = ENDED;
      default:  state_d = ENDED;
    endcase

    ending_d = (state_d == ENDED) && (state_q != ENDED);
    ended_d  = ended_q || ending_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      wait_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ending_q <= 1'b0;
      ended_q  <= 1'b0;
      state_q  <= RUN;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      ovf_q    <= ovf_d;
      ending_q <= ending_d;
      ended_q  <= ended_d;
      state_q  <= state_d;
    end
  end

  assign dct_buffer     = out_frame.buffer;
  assign dct_count      = out_frame.count;
  assign overflow       = ovf_q;
  assign test_ending    = ending_q;
  assign test_has_ended = ended_q;

endmodule

// File: tb/tb_core7_cpu_5_oci_dct_packer.sv
// Scoreboard bench for the DCT packer: stimulus pushes expected frames, a negedge monitor pops them on handshake.
module tb_core7_cpu_5_oci_dct_packer;
  import core7_cpu_5_oci_dct_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              trc_on = 1'b0;
  logic              dct_valid = 1'b0;
  logic [CODE_W-1:0] dct_code = '0;
  logic              dct_flush = 1'b0;
  logic              trc_stop = 1'b0;
  logic              frame_ready = 1'b0;
  logic              ovf_clr = 1'b0;
  logic              frame_valid;
  logic [BUF_W-1:0]  dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              overflow;
  logic              test_ending;
  logic              test_has_ended;

  core7_cpu_5_oci_dct_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .trc_on         (trc_on),
    .dct_valid      (dct_valid),
    .dct_code       (dct_code),
    .dct_flush      (dct_flush),
    .trc_stop       (trc_stop),
    .frame_ready    (frame_ready),
    .frame_valid    (frame_valid),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .overflow       (overflow),
    .ovf_clr        (ovf_clr),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  dct_frame_t sb[$];
  int n_cmp = 0, n_err = 0;
  int mon_cmp = 0, mon_err = 0;

  // Monitor: every handshake must match the oldest expected frame.
  always @(negedge clk) begin
    if (reset_n && frame_valid && frame_ready) begin
      mon_cmp++;
      if (sb.size() == 0) begin
        mon_err++;
        $display("FAIL frame_unexpected: got count=%0d buffer=%h, none expected", dct_count, dct_buffer);
      end else begin
        dct_frame_t e;
        e = sb.pop_front();
        if (dct_count !== e.count || dct_buffer !== e.buffer) begin
          mon_err++;
          $display("FAIL frame: got count=%0d buffer=%h, want count=%0d buffer=%h",
                   dct_count, dct_buffer, e.count, e.buffer);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c, input logic fl);
    dct_valid = 1'b1;
    dct_code  = c;
    dct_flush = fl;
    cyc();
    dct_valid = 1'b0;
    dct_flush = 1'b0;
  endtask

  function automatic dct_frame_t mk(input logic [CNT_W-1:0] c, input logic [BUF_W-1:0] b);
    dct_frame_t f;
    f.count  = c;
    f.buffer = b;
    return f;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    cyc();
    chk("rst_frame_valid", 32'(frame_valid), 0);
    chk("rst_dct_buffer", 32'(dct_buffer), 0);
    chk("rst_dct_count", 32'(dct_count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_test_ending", 32'(test_ending), 0);
    chk("rst_test_has_ended", 32'(test_has_ended), 0);
    reset_n = 1'b1;
    trc_on = 1'b1;
    frame_ready = 1'b1;
    cyc();

    // 15 taken codes -> full frame
    sb.push_back(mk(4'd15, 30'h15555555));
    for (int i = 0; i < 14; i++) send(2'b01, 1'b0);
    chk("full_not_yet_valid", 32'(frame_valid), 0);
    send(2'b01, 1'b0);
    chk("full_valid_next_cycle", 32'(frame_valid), 1);

    // 01,10,11 with flush on the third code
    sb.push_back(mk(4'd3, 30'h39));
    send(2'b01, 1'b0);
    send(2'b10, 1'b0);
    send(2'b11, 1'b1);
    chk("flush_valid", 32'(frame_valid), 1);
    chk("flush_count", 32'(dct_count), 3);
    dct_flush = 1'b1;
    cyc();
    dct_flush = 1'b0;
    chk("empty_flush_no_frame", 32'(frame_valid), 0);

    // Back-pressure: one frame out, one in WAIT, rest dropped
    frame_ready = 1'b0;
    sb.push_back(mk(4'd15, 30'h2AAAAAAA));
    sb.push_back(mk(4'd15, 30'h2AAAAAAA));
    for (int i = 0; i < 40; i++) send(2'b10, 1'b0);
    chk("bp_valid_held", 32'(frame_valid), 1);
    chk("bp_count_held", 32'(dct_count), 15);
    chk("bp_overflow_set", 32'(overflow), 1);
    frame_ready = 1'b1;
    cyc();
    chk("bp_back_to_back", 32'(frame_valid), 1);
    cyc();
    chk("bp_drained", 32'(frame_valid), 0);
    chk("bp_overflow_sticky", 32'(overflow), 1);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);

    // 5 codes, stop, then ignored codes
    sb.push_back(mk(4'd5, 30'h279));
    send(2'b01, 1'b0);
    send(2'b10, 1'b0);
    send(2'b11, 1'b0);
    send(2'b01, 1'b0);
    send(2'b10, 1'b0);
    trc_stop = 1'b1;
    cyc();
    trc_stop = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      send(2'b01, (i == 10));
      if (test_ending) pulses++;
    end
    chk("ending_pulse_count", 32'(pulses), 1);
    chk("has_ended_sticky", 32'(test_has_ended), 1);
    chk("ended_no_frame", 32'(frame_valid), 0);

    // Async reset with a stalled frame pending
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    frame_ready = 1'b0;
    for (int i = 0; i < 17; i++) send(2'b11, 1'b0);
    chk("pre_reset_valid", 32'(frame_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_frame_valid", 32'(frame_valid), 0);
    chk("async_dct_buffer", 32'(dct_buffer), 0);
    chk("async_dct_count", 32'(dct_count), 0);
    chk("async_test_has_ended", 32'(test_has_ended), 0);
    cyc();
    reset_n = 1'b1;
    frame_ready = 1'b1;
    cyc();
    sb.push_back(mk(4'd1, 30'h3));
    send(2'b11, 1'b1);
    chk("post_reset_count", 32'(dct_count), 1);
    cyc();
    cyc();
    chk("scoreboard_empty", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + mon_cmp, n_err + mon_err);
    $finish;
  end

endmodule
